// File: rtl/enoc_switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking until the tail flit.
// Zero-cycle latency: grants and crossbar selects are combinational from state and inputs.
// An output grants only when i_output_ready is high; otherwise the flit stays queued and any lock is held.
module enoc_switch_allocator #(
    parameter int N     = 5,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N*N-1:0]       i_output_req,
    input  logic [N-1:0]         i_tail,
    input  logic [N-1:0]         i_output_ready,
    output logic [N-1:0]         o_input_grant,
    output logic [N*SEL_W-1:0]   o_xbar_sel,
    output logic [N-1:0]         o_output_val
);

    typedef enum logic {ST_IDLE, ST_LOCKED} st_e;

    st_e              state_q [N];
    st_e              state_d [N];
    logic [SEL_W-1:0] owner_q [N];
    logic [SEL_W-1:0] owner_d [N];
    logic [SEL_W-1:0] ptr_q   [N];
    logic [SEL_W-1:0] ptr_d   [N];

    logic [N-1:0]       win_vld;
    logic [SEL_W-1:0]   win_idx [N];
    logic [N-1:0]       grant_c;
    logic [N-1:0]       val_c;
    logic [N*SEL_W-1:0] sel_c;

    // Search starts one past the last granted input, so the last winner has lowest priority.
    always_comb begin
        for (int o = 0; o < N; o++) begin
            win_vld[o] = 1'b0;
            win_idx[o] = '0;
            for (int k = 1; k <= N; k++) begin
                if (!win_vld[o] && i_output_req[((int'(ptr_q[o]) + k) % N) * N + o]) begin
                    win_vld[o] = 1'b1;
                    win_idx[o] = SEL_W'((int'(ptr_q[o]) + k) % N);
                end
            end
        end
    end

    always_comb begin
        grant_c = '0;
        val_c   = '0;
        sel_c   = '0;
        for (int o = 0; o < N; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            if (state_q[o] == ST_LOCKED) begin
                // Only the owner is served; a bubble or missing credit leaves the lock in place.
                if (i_output_req[int'(owner_q[o]) * N + o] && i_output_ready[o]) begin
                    val_c[o]                   = 1'b1;
                    sel_c[o*SEL_W +: SEL_W]    = owner_q[o];
                    grant_c[owner_q[o]]        = 1'b1;
                    if (i_tail[owner_q[o]]) begin
                        state_d[o] = ST_IDLE;
                    end
                end
            end else if (win_vld[o] && i_output_ready[o]) begin
                val_c[o]                = 1'b1;
                sel_c[o*SEL_W +: SEL_W] = win_idx[o];
                grant_c[win_idx[o]]     = 1'b1;
                ptr_d[o]                = win_idx[o];
                if (!i_tail[win_idx[o]]) begin
                    state_d[o] = ST_LOCKED;
                    owner_d[o] = win_idx[o];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < N; o++) begin
                state_q[o] <= ST_IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= SEL_W'(N - 1);
            end
        end else begin
            for (int o = 0; o < N; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

    // Outputs are forced quiet for the whole reset window, even with requests pending.
    assign o_input_grant = reset_n ? grant_c : '0;
    assign o_output_val  = reset_n ? val_c   : '0;
    assign o_xbar_sel    = reset_n ? sel_c   : '0;

endmodule

// File: tb/tb_enoc_switch_allocator.sv
module tb_enoc_switch_allocator;
    localparam int N = 5;
    localparam int S = 3;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [N*N-1:0]     i_output_req;
    logic [N-1:0]       i_tail;
    logic [N-1:0]       i_output_ready;
    logic [N-1:0]       o_input_grant;
    logic [N*S-1:0]     o_xbar_sel;
    logic [N-1:0]       o_output_val;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string          tag;
        logic [N-1:0]   g;
        logic [N-1:0]   v;
        logic [N*S-1:0] s;
    } exp_t;
    exp_t sb[$];

    enoc_switch_allocator #(.N(N), .SEL_W(S)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_output_req   (i_output_req),
        .i_tail         (i_tail),
        .i_output_ready (i_output_ready),
        .o_input_grant  (o_input_grant),
        .o_xbar_sel     (o_xbar_sel),
        .o_output_val   (o_output_val)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [N*N-1:0] rq(input int i, input int o);
        logic [N*N-1:0] r;
        r = '0;
        r[i*N+o] = 1'b1;
        return r;
    endfunction

    function automatic logic [N-1:0] b(input int i);
        logic [N-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [N*S-1:0] sl(input int o, input int i);
        logic [N*S-1:0] r;
        r = '0;
        r[o*S +: S] = S'(i);
        return r;
    endfunction

    task automatic expect_out(input string tag, input logic [N-1:0] g,
                              input logic [N-1:0] v, input logic [N*S-1:0] s);
        exp_t e;
        e.tag = tag; e.g = g; e.v = v; e.s = s;
        sb.push_back(e);
    endtask

    task automatic cmp();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty got %0d entries required >0", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (o_input_grant === e.g) else begin
                errors++;
                $error("FAIL %s grant got %b required %b", e.tag, o_input_grant, e.g);
            end
            checks++;
            assert (o_output_val === e.v) else begin
                errors++;
                $error("FAIL %s val got %b required %b", e.tag, o_output_val, e.v);
            end
            checks++;
            assert (o_xbar_sel === e.s) else begin
                errors++;
                $error("FAIL %s sel got %h required %h", e.tag, o_xbar_sel, e.s);
            end
            checks++;
            assert ((o_output_val & ~i_output_ready) == '0) else begin
                errors++;
                $error("FAIL %s val_without_ready got %b ready %b", e.tag, o_output_val, i_output_ready);
            end
        end
    endtask

    // Drive one cycle of stimulus just after the edge, check outputs at the falling edge.
    task automatic step(input string tag, input logic [N*N-1:0] rqv, input logic [N-1:0] tl,
                        input logic [N-1:0] rdy, input logic [N-1:0] g,
                        input logic [N-1:0] v, input logic [N*S-1:0] s);
        @(posedge clk);
        #1;
        i_output_req   = rqv;
        i_tail         = tl;
        i_output_ready = rdy;
        for (int i = 0; i < N; i++) begin
            assert ($onehot0(i_output_req[i*N +: N])) else begin
                errors++;
                $error("FAIL %s multi_hot_req input %0d got %b required onehot0", tag, i, i_output_req[i*N +: N]);
            end
        end
        expect_out(tag, g, v, s);
        @(negedge clk);
        cmp();
    endtask

    localparam logic [N-1:0] ALL = '1;

    initial begin
        reset_n        = 1'b0;
        i_output_req   = rq(2, 2);
        i_tail         = '0;
        i_output_ready = ALL;
        expect_out("reset_async", '0, '0, '0);
        #3;
        cmp();
        expect_out("reset_edge", '0, '0, '0);
        @(posedge clk);
        @(negedge clk);
        cmp();
        reset_n      = 1'b1;
        i_output_req = '0;

        // 1: 3-flit packet input 2 -> east; input 1 competing while locked
        step("t1_head", rq(2,2),           '0,   ALL, b(2), b(2), sl(2,2));
        step("t1_body", rq(2,2)|rq(1,2),   '0,   ALL, b(2), b(2), sl(2,2));
        step("t1_tail", rq(2,2)|rq(1,2),   b(2), ALL, b(2), b(2), sl(2,2));
        step("t1_idle", rq(3,2),           b(3), ALL, b(3), b(2), sl(2,3));

        // 2: round robin between inputs 1 and 3 on output 0
        for (int k = 0; k < 4; k++) begin
            step($sformatf("t2_rr%0d", k), rq(1,0)|rq(3,0), b(1)|b(3), ALL,
                 (k % 2 == 0) ? b(1) : b(3), b(0), sl(0, (k % 2 == 0) ? 1 : 3));
        end

        // 3: input 4 holds output 1; input 0 waits for the tail
        step("t3_head",  rq(4,1),         '0,   ALL, b(4), b(1), sl(1,4));
        step("t3_body0", rq(4,1)|rq(0,1), '0,   ALL, b(4), b(1), sl(1,4));
        step("t3_body1", rq(4,1)|rq(0,1), '0,   ALL, b(4), b(1), sl(1,4));
        step("t3_tail",  rq(4,1)|rq(0,1), b(4), ALL, b(4), b(1), sl(1,4));
        step("t3_next",  rq(0,1),         b(0), ALL, b(0), b(1), sl(1,0));

        // 4: owner bubble on output 4 with a rival requester
        step("t4_head",  rq(2,4),         '0,   ALL, b(2), b(4), sl(4,2));
        step("t4_gap0",  rq(1,4),         '0,   ALL, '0,   '0,   '0);
        step("t4_gap1",  rq(1,4),         '0,   ALL, '0,   '0,   '0);
        step("t4_body",  rq(2,4)|rq(1,4), '0,   ALL, b(2), b(4), sl(4,2));
        step("t4_tail",  rq(2,4),         b(2), ALL, b(2), b(4), sl(4,2));

        // 5: no credit on output 3 while input 1 is locked
        step("t5_head",  rq(1,3),         '0,   ALL, b(1), b(3), sl(3,1));
        for (int k = 0; k < 3; k++) begin
            step($sformatf("t5_stall%0d", k), rq(1,3)|rq(0,3), '0, ALL & ~b(3), '0, '0, '0);
        end
        step("t5_resume", rq(1,3)|rq(0,3), '0,  ALL, b(1), b(3), sl(3,1));
        step("t5_tail",   rq(1,3),         b(1), ALL, b(1), b(3), sl(3,1));

        // 6: asynchronous reset in the middle of a packet
        step("t6_head", rq(0,2), '0, ALL, b(0), b(2), sl(2,0));
        @(posedge clk);
        #1;
        i_output_req = rq(0,2);
        i_tail       = '0;
        #1;
        reset_n = 1'b0;
        expect_out("t6_in_reset", '0, '0, '0);
        #1;
        cmp();
        @(posedge clk);
        @(negedge clk);
        reset_n      = 1'b1;
        i_output_req = '0;
        step("t6_fresh", rq(3,2), b(3), ALL, b(3), b(2), sl(2,3));

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover got %0d required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
